// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store sequencer over a 32-bit big-endian memory window
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_out32
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      state, state_next;
  logic        l_write, l_signed, l_err;
  logic [1:0]  l_size;
  logic [5:0]  l_addr;
  logic [31:0] l_wdata;
  logic [31:0] rd;
  logic        accept;
  logic        req_err;
  logic [31:0] load_result;

  assign accept = req_valid && req_ready;

  // Reject reserved size, misalignment, and any access whose 4-byte window would pass byte 50
  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_RSVD) req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0]) req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr > 6'd47) req_err = 1'b1;
  end

  // State register, request latch and read-capture register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      l_write  <= 1'b0;
      l_signed <= 1'b0;
      l_err    <= 1'b0;
      l_size   <= 2'b00;
      l_addr   <= 6'd0;
      l_wdata  <= 32'd0;
      rd       <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        l_write  <= req_write;
        l_signed <= req_signed;
        l_err    <= req_err;
        l_size   <= req_size;
        l_addr   <= req_addr;
        l_wdata  <= req_wdata;
      end
      if (state == READ) rd <= mem_out32;
    end
  end

  // Next state: sub-word stores read first so untouched bytes are written back unchanged
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_next = RESP;
          else if (!req_write)          state_next = READ;
          else if (req_size == SZ_WORD) state_next = WRITE;
          else                          state_next = READ;
        end
      end
      READ:    state_next = l_write ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load data extraction from the big-endian capture (addressed byte sits in bits 31:24)
  always_comb begin
    load_result = rd;
    case (l_size)
      SZ_HALF: load_result = {{16{l_signed & rd[31]}}, rd[31:16]};
      SZ_BYTE: load_result = {{24{l_signed & rd[31]}}, rd[31:24]};
      default: load_result = rd;
    endcase
  end

  // Memory and response outputs; strobes are gated by reset so an in-flight write is dropped
  always_comb begin
    req_ready     = (state == IDLE);
    mem_memread   = (state == READ) && !rst;
    mem_memwrite  = (state == WRITE) && !rst;
    mem_address   = 6'd0;
    mem_writeData = 32'd0;
    resp_valid    = (state == RESP) && !rst;
    resp_err      = resp_valid && l_err;
    resp_rdata    = 32'd0;
    if (state == READ || state == WRITE) mem_address = l_addr;
    if (state == WRITE) begin
      case (l_size)
        SZ_WORD: mem_writeData = l_wdata;
        SZ_HALF: mem_writeData = {l_wdata[15:0], rd[15:0]};
        default: mem_writeData = {l_wdata[7:0], rd[23:0]};
      endcase
    end
    if (resp_valid && !l_write && !l_err) resp_rdata = load_result;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed plus random checks of load_store_unit against a byte-array model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [5:0]  mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memwrite, mem_memread;
  logic [31:0] mem_out32;

  logic [7:0]  tbmem [64];
  logic [7:0]  model_mem [64];
  logic        load_init;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_data;
  logic        last_err;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_out32(mem_out32)
  );

  // Combinational big-endian read window
  assign mem_out32 = {tbmem[mem_address], tbmem[mem_address + 6'd1],
                      tbmem[mem_address + 6'd2], tbmem[mem_address + 6'd3]};

  // Backing memory: bulk load from the model at start, then 4-byte big-endian writes
  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < 64; i++) tbmem[i] <= model_mem[i];
    end else if (mem_memwrite) begin
      tbmem[mem_address]        <= mem_writeData[31:24];
      tbmem[mem_address + 6'd1] <= mem_writeData[23:16];
      tbmem[mem_address + 6'd2] <= mem_writeData[15:8];
      tbmem[mem_address + 6'd3] <= mem_writeData[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // One transaction: expectations come from byte-array rules, then the DUT is driven and observed
  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [5:0] a, input logic [31:0] wd);
    logic e;
    int   exp_lat, exp_nr, exp_nw, lat, nr, nw;
    logic [31:0] exp_data, word;
    logic [15:0] h;
    logic [7:0]  b;
    logic got_valid;
    int   ai;
    ai = int'(a);
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (ai > 47);
    exp_data = 32'd0;
    if (!e && !w) begin
      word = {model_mem[ai], model_mem[ai+1], model_mem[ai+2], model_mem[ai+3]};
      h = {model_mem[ai], model_mem[ai+1]};
      b = model_mem[ai];
      if (sz == 2'd2)      exp_data = word;
      else if (sz == 2'd1) exp_data = sg ? 32'($signed(h)) : {16'd0, h};
      else                 exp_data = sg ? 32'($signed(b)) : {24'd0, b};
    end
    exp_lat = e ? 1 : ((w && sz != 2'd2) ? 3 : 2);
    exp_nr  = (!e && (!w || sz != 2'd2)) ? 1 : 0;
    exp_nw  = (!e && w) ? 1 : 0;

    wait_ready();
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // keep a garbage request pending while busy; it must be ignored
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = 6'($urandom); req_wdata = $urandom;
    lat = 0; nr = 0; nw = 0; got_valid = 1'b0;
    last_data = 32'hxxxxxxxx; last_err = 1'bx;
    for (int i = 0; i < 8; i++) begin
      lat++;
      if (mem_memread) nr++;
      if (mem_memwrite) nw++;
      if (resp_valid) begin
        got_valid = 1'b1; last_data = resp_rdata; last_err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'd0, last_err}, {31'd0, e});
    check({tag, "_rdata"}, last_data, exp_data);
    check({tag, "_nread"}, nr, exp_nr);
    check({tag, "_nwrite"}, nw, exp_nw);
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
    if (!e && w) begin
      if (sz == 2'd2) begin
        model_mem[ai] = wd[31:24]; model_mem[ai+1] = wd[23:16];
        model_mem[ai+2] = wd[15:8]; model_mem[ai+3] = wd[7:0];
      end else if (sz == 2'd1) begin
        model_mem[ai] = wd[15:8]; model_mem[ai+1] = wd[7:0];
      end else begin
        model_mem[ai] = wd[7:0];
      end
    end
  endtask

  initial begin
    int diff;
    int saw_valid;
    rst = 1'b1; load_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 6'd0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) model_mem[i] = 8'($urandom);
    model_mem[0] = 8'h00; model_mem[1] = 8'h43; model_mem[2] = 8'h08; model_mem[3] = 8'h22;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; load_init = 1'b0;

    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    check("rst_addr", {26'd0, mem_address}, 32'd0);
    check("rst_wdata", mem_writeData, 32'd0);

    run("lw0", 1'b0, 2'd2, 1'b0, 6'd0, 32'd0);
    check("lw0_const", last_data, 32'h00430822);
    run("sw8", 1'b1, 2'd2, 1'b0, 6'd8, 32'h80FF1234);
    run("lb8", 1'b0, 2'd0, 1'b1, 6'd8, 32'd0);
    check("lb8_const", last_data, 32'hFFFFFF80);
    run("lbu8", 1'b0, 2'd0, 1'b0, 6'd8, 32'd0);
    check("lbu8_const", last_data, 32'h00000080);
    run("lh10", 1'b0, 2'd1, 1'b1, 6'd10, 32'd0);
    check("lh10_const", last_data, 32'h00001234);
    run("sb9", 1'b1, 2'd0, 1'b0, 6'd9, 32'h000000AB);
    run("lw8", 1'b0, 2'd2, 1'b0, 6'd8, 32'd0);
    check("lw8_const", last_data, 32'h80AB1234);
    run("sh5", 1'b1, 2'd1, 1'b0, 6'd5, 32'h5555AAAA);
    run("lw6", 1'b0, 2'd2, 1'b0, 6'd6, 32'd0);
    run("lb48", 1'b0, 2'd0, 1'b0, 6'd48, 32'd0);
    run("lb47", 1'b0, 2'd0, 1'b1, 6'd47, 32'd0);
    run("rsvd", 1'b1, 2'd3, 1'b0, 6'd16, 32'hFFFFFFFF);
    run("sh46", 1'b1, 2'd1, 1'b0, 6'd46, 32'h0000BEEF);

    // reset while a word store sits in WRITE: the write must be suppressed
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 6'd12; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstw_inwrite", {31'd0, mem_memwrite}, 32'd0 | {31'd0, 1'b1});
    rst = 1'b1; #1;
    check("rstw_gated", {31'd0, mem_memwrite}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    saw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) saw_valid++;
      @(posedge clk); #1;
    end
    check("rstw_noresp", saw_valid, 0);
    run("lw12", 1'b0, 2'd2, 1'b0, 6'd12, 32'd0);

    for (int n = 0; n < 80; n++) begin
      logic [1:0] sz;
      logic [5:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 47));
      if (($urandom_range(0, 3) != 0) && sz == 2'd2) a[1:0] = 2'd0;
      if (($urandom_range(0, 3) != 0) && sz == 2'd1) a[0] = 1'b0;
      run("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    diff = 0;
    for (int i = 0; i < 64; i++) if (tbmem[i] !== model_mem[i]) diff++;
    check("mem_final", diff, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
